// File: rtl/chimera_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chimera_pkg
//  Description : Shared Chimera SoC constants and bus typedefs. Provides the
//                register-bus and APB4 structs, the ExtCfgRegs region bounds
//                and the reg-to-APB bridge state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package chimera_pkg;

    localparam int unsigned RegAddrWidth = 32;
    localparam int unsigned RegDataWidth = 32;

    localparam logic [31:0] ExtCfgRegsRegionStart = 32'h3000_2000;
    localparam logic [31:0] ExtCfgRegsRegionEnd   = 32'h3000_5000;
    localparam int unsigned ExtCfgRegsRegionSize  = ExtCfgRegsRegionEnd - ExtCfgRegsRegionStart;
    localparam int unsigned ExtCfgRegsTimeoutCycles = 256;

    typedef struct packed {
        logic                      valid;
        logic                      write;
        logic [RegAddrWidth-1:0]   addr;
        logic [RegDataWidth-1:0]   wdata;
        logic [RegDataWidth/8-1:0] wstrb;
    } reg_req_t;

    typedef struct packed {
        logic                    ready;
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
    } reg_rsp_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } reg_to_apb_state_e;

endpackage
`default_nettype wire

// File: rtl/chimera_reg_to_apb.sv
`default_nettype none
// ============================================================================
//  Module      : chimera_reg_to_apb
//  Description : Register-bus slave to APB4 requester bridge for the
//                ExtCfgRegs region. Each register-bus request becomes one
//                APB SETUP/ACCESS transfer; the completion is returned as a
//                single-cycle register-bus response. Out-of-region requests
//                are answered with an error and no APB activity, and a
//                pready timeout keeps a hung completer from stalling the bus.
//  Ports       : clk_i      - clock
//                rst_ni     - asynchronous active-low reset
//                reg_req_i  - register-bus request (held until ready)
//                reg_rsp_o  - register-bus response (ready is a 1-cycle pulse)
//                apb_req_o  - APB4 request
//                apb_rsp_i  - APB4 response
//                busy_o     - high whenever a request is in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module chimera_reg_to_apb
    import chimera_pkg::*;
#(
    parameter int unsigned       AddrWidth     = 32,
    parameter int unsigned       DataWidth     = RegDataWidth,
    parameter logic [AddrWidth-1:0] BaseAddr   = ExtCfgRegsRegionStart,
    parameter int unsigned       RegionSize    = ExtCfgRegsRegionSize,
    parameter int unsigned       TimeoutCycles = ExtCfgRegsTimeoutCycles,
    parameter type               reg_req_t     = chimera_pkg::reg_req_t,
    parameter type               reg_rsp_t     = chimera_pkg::reg_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  reg_req_t              reg_req_i,
    output reg_rsp_t              reg_rsp_o,
    output chimera_pkg::apb_req_t apb_req_o,
    input  chimera_pkg::apb_resp_t apb_rsp_i,
    output logic                  busy_o
);

    // Region bounds are compared one bit wider so BaseAddr+RegionSize
    // cannot wrap at the top of the address space.
    localparam int unsigned            c_aw1       = AddrWidth + 1;
    localparam logic [AddrWidth:0]     c_region_lo = {1'b0, BaseAddr};
    localparam logic [AddrWidth:0]     c_region_hi = {1'b0, BaseAddr} + c_aw1'(RegionSize);

    localparam int unsigned            c_cnt_w   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [c_cnt_w-1:0]     c_cnt_max = c_cnt_w'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    reg_to_apb_state_e          r_state;
    reg_to_apb_state_e          w_state_next;

    logic                       r_write;
    logic [AddrWidth-1:0]       r_paddr;
    logic [DataWidth-1:0]       r_pwdata;
    logic [DataWidth/8-1:0]     r_pstrb;
    logic [DataWidth-1:0]       r_rdata;
    logic                       r_error;
    logic [c_cnt_w-1:0]         r_cnt;

    logic                       w_in_region;
    logic                       w_timeout;

    assign w_in_region = ({1'b0, reg_req_i.addr} >= c_region_lo) &&
                         ({1'b0, reg_req_i.addr} <  c_region_hi);

    // Expiry only matters while pready is low; a pready in the expiry cycle
    // wins and completes the transfer normally.
    assign w_timeout = (TimeoutCycles != 0) && (r_cnt == c_cnt_max) && !apb_rsp_i.pready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        apb_req_o    = '0;
        reg_rsp_o    = '0;
        busy_o       = 1'b0;

        case (r_state)
            IDLE: begin
                if (reg_req_i.valid) begin
                    w_state_next = w_in_region ? SETUP : RESP;
                end
            end
            SETUP: begin
                w_state_next = ACCESS;
            end
            ACCESS: begin
                if (apb_rsp_i.pready || w_timeout) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        apb_req_o.psel    = (r_state == SETUP) || (r_state == ACCESS);
        apb_req_o.penable = (r_state == ACCESS);
        apb_req_o.pwrite  = r_write;
        apb_req_o.paddr   = r_paddr;
        apb_req_o.pwdata  = r_pwdata;
        apb_req_o.pstrb   = r_pstrb;
        apb_req_o.pprot   = 3'b000;

        reg_rsp_o.ready   = (r_state == RESP);
        reg_rsp_o.rdata   = r_rdata;
        reg_rsp_o.error   = r_error;

        busy_o            = (r_state != IDLE);
    end

    // ------------------------------------------------------------------
    // Request latch, response capture and pready timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_write  <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (reg_req_i.valid) begin
                        r_write  <= reg_req_i.write;
                        r_paddr  <= AddrWidth'(reg_req_i.addr - BaseAddr);
                        // Reads present all-zero write data and strobes.
                        r_pwdata <= reg_req_i.write ? reg_req_i.wdata : '0;
                        r_pstrb  <= reg_req_i.write ? reg_req_i.wstrb : '0;
                        r_cnt    <= '0;
                        r_rdata  <= '0;
                        r_error  <= !w_in_region;
                    end
                end
                ACCESS: begin
                    if (apb_rsp_i.pready) begin
                        r_rdata <= r_write ? '0 : apb_rsp_i.prdata;
                        r_error <= apb_rsp_i.pslverr;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chimera_reg_to_apb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chimera_reg_to_apb
//  Description : Self-checking bench for chimera_reg_to_apb. A behavioural
//                APB completer with configurable wait states drives the DUT;
//                every request is predicted from the bridge's external rules
//                (region, latency, error and data) and checked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chimera_reg_to_apb;

    localparam logic [31:0] BASE = 32'h3000_2000;
    localparam logic [31:0] LIMIT = 32'h3000_5000;
    localparam int          TMO  = 256;
    localparam int          HANG = 100000;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    chimera_pkg::reg_req_t  req;
    chimera_pkg::reg_rsp_t  rsp;
    chimera_pkg::apb_req_t  apb_req;
    chimera_pkg::apb_resp_t apb_rsp;
    logic                   busy;

    int          tests = 0;
    int          fails = 0;

    // completer configuration
    int          cfg_wait = 0;
    logic [31:0] cfg_prdata = '0;
    logic        cfg_pslverr = 1'b0;
    int          acc_cnt;

    // transfer monitor
    int          sel_cnt = 0;
    int          xfer_cnt = 0;
    logic [31:0] last_paddr = '0;
    logic [31:0] last_pwdata = '0;

    always #5 clk_i = ~clk_i;

    chimera_reg_to_apb #(
        .AddrWidth     (32),
        .DataWidth     (32),
        .BaseAddr      (BASE),
        .RegionSize    (32'h3000),
        .TimeoutCycles (TMO)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .reg_req_i (req),
        .reg_rsp_o (rsp),
        .apb_req_o (apb_req),
        .apb_rsp_i (apb_rsp),
        .busy_o    (busy)
    );

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) acc_cnt <= 0;
        else if (apb_req.psel && apb_req.penable && !apb_rsp.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always_comb begin
        apb_rsp         = '0;
        apb_rsp.pready  = apb_req.psel && apb_req.penable && (acc_cnt == cfg_wait);
        apb_rsp.prdata  = cfg_prdata;
        apb_rsp.pslverr = cfg_pslverr;
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (apb_req.psel) sel_cnt <= sel_cnt + 1;
            if (apb_req.psel && apb_req.penable && apb_rsp.pready) begin
                xfer_cnt    <= xfer_cnt + 1;
                last_paddr  <= apb_req.paddr;
                last_pwdata <= apb_req.pwdata;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One register-bus request, predicted from the bridge's rules:
    // out of region -> 1-cycle error, in region -> 3+wait cycles, and a
    // completer needing TMO or more wait states hits the timeout.
    task automatic do_xfer(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws, input int wst,
                           input logic [31:0] prd, input bit serr);
        bit          in_rng, hung, seen;
        int          exp_lat, exp_sel, exp_xf, lat, sel0, xf0;
        bit          exp_err;
        logic [31:0] exp_rd;
        in_rng  = (addr >= BASE) && (addr < LIMIT);
        hung    = in_rng && (wst >= TMO);
        exp_lat = !in_rng ? 1 : (hung ? 2 + TMO : 3 + wst);
        exp_sel = !in_rng ? 0 : (hung ? 1 + TMO : 2 + wst);
        exp_xf  = (in_rng && !hung) ? 1 : 0;
        exp_err = !in_rng || hung || serr;
        exp_rd  = (in_rng && !hung && !wr) ? prd : 32'h0;

        @(negedge clk_i);
        cfg_wait    = wst;
        cfg_prdata  = prd;
        cfg_pslverr = serr;
        sel0        = sel_cnt;
        xf0         = xfer_cnt;
        req.valid   = 1'b1;
        req.write   = wr;
        req.addr    = addr;
        req.wdata   = wd;
        req.wstrb   = ws;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 400) begin
            @(negedge clk_i);
            lat++;
            if (lat == 1 && in_rng) begin
                check({tag, ".setup_psel"},    32'(apb_req.psel), 32'd1);
                check({tag, ".setup_penable"}, 32'(apb_req.penable), 32'd0);
                check({tag, ".pwrite"},        32'(apb_req.pwrite), 32'(wr));
                check({tag, ".paddr"},         apb_req.paddr, addr - BASE);
                check({tag, ".pwdata"},        apb_req.pwdata, wr ? wd : 32'h0);
                check({tag, ".pstrb"},         32'(apb_req.pstrb), wr ? 32'(ws) : 32'h0);
                check({tag, ".pprot"},         32'(apb_req.pprot), 32'd0);
                check({tag, ".busy"},          32'(busy), 32'd1);
            end
            if (lat == 2 && in_rng) begin
                check({tag, ".access_penable"}, 32'(apb_req.penable && apb_req.psel), 32'd1);
            end
            if (rsp.ready) seen = 1;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".error"},   32'(rsp.error), 32'(exp_err));
        check({tag, ".rdata"},   rsp.rdata, exp_rd);
        req = '0;
        @(negedge clk_i);
        check({tag, ".ready_pulse"}, 32'(rsp.ready), 32'd0);
        check({tag, ".idle_busy"},   32'(busy), 32'd0);
        check({tag, ".idle_psel"},   32'(apb_req.psel), 32'd0);
        check({tag, ".sel_cycles"},  32'(sel_cnt - sel0), 32'(exp_sel));
        check({tag, ".transfers"},   32'(xfer_cnt - xf0), 32'(exp_xf));
        if (exp_xf == 1) begin
            check({tag, ".xfer_paddr"},  last_paddr, addr - BASE);
            check({tag, ".xfer_pwdata"}, last_pwdata, wr ? wd : 32'h0);
        end
    endtask

    initial begin
        req = '0;
        repeat (3) @(negedge clk_i);
        check("reset.psel",    32'(apb_req.psel), 32'd0);
        check("reset.penable", 32'(apb_req.penable), 32'd0);
        check("reset.paddr",   apb_req.paddr, 32'h0);
        check("reset.pwdata",  apb_req.pwdata, 32'h0);
        check("reset.pstrb",   32'(apb_req.pstrb), 32'd0);
        check("reset.ready",   32'(rsp.ready), 32'd0);
        check("reset.rdata",   rsp.rdata, 32'h0);
        check("reset.error",   32'(rsp.error), 32'd0);
        check("reset.busy",    32'(busy), 32'd0);
        rst_ni = 1'b1;

        do_xfer("wr_basic",  1'b1, 32'h3000_2010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
        do_xfer("rd_wait3",  1'b0, 32'h3000_4FFC, 32'hFFFF_FFFF, 4'hF, 3, 32'h1234_5678, 1'b0);
        do_xfer("rd_oor_hi", 1'b0, 32'h3000_5000, 32'h0, 4'h0, 0, 32'hAAAA_AAAA, 1'b0);
        do_xfer("rd_oor_lo", 1'b0, 32'h3000_1FFC, 32'h0, 4'h0, 0, 32'hAAAA_AAAA, 1'b0);
        do_xfer("wr_slverr", 1'b1, 32'h3000_3000, 32'h0BAD_F00D, 4'h3, 0, 32'h5555_5555, 1'b1);
        do_xfer("rd_base",   1'b0, 32'h3000_2000, 32'h0, 4'h0, 0, 32'hCAFE_0001, 1'b0);
        do_xfer("wr_w255",   1'b1, 32'h3000_2400, 32'h1111_2222, 4'hC, TMO - 1, 32'h0, 1'b0);
        do_xfer("rd_tmo",    1'b0, 32'h3000_2404, 32'h0, 4'h0, HANG, 32'h7777_7777, 1'b0);

        // reset in the middle of an ACCESS phase
        @(negedge clk_i);
        cfg_wait  = HANG;
        req.valid = 1'b1;
        req.write = 1'b1;
        req.addr  = 32'h3000_2100;
        req.wdata = 32'h0123_4567;
        req.wstrb = 4'hF;
        repeat (4) @(negedge clk_i);
        check("mid_rst.pre_penable", 32'(apb_req.penable), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst.psel",    32'(apb_req.psel), 32'd0);
        check("mid_rst.penable", 32'(apb_req.penable), 32'd0);
        check("mid_rst.busy",    32'(busy), 32'd0);
        check("mid_rst.ready",   32'(rsp.ready), 32'd0);
        @(negedge clk_i);
        req = '0;
        check("mid_rst.ready_hold", 32'(rsp.ready), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_xfer("wr_after_rst", 1'b1, 32'h3000_2020, 32'h89AB_CDEF, 4'h5, 0, 32'h0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = (32'h3000_1F00 + $urandom_range(0, 32'h3200)) & 32'hFFFF_FFFC;
            do_xfer($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 4)), $urandom,
                    ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chimera_reg_to_apb.md
Name: chimera_reg_to_apb

Overview:
- Bridge from the register-bus slave port of the ExtCfgRegs region (0x3000_2000–0x3000_5000) to an APB4 requester port.
- Drives the external configuration completers (pads, FLLs, PMU controller) using the package APB typedefs.
- Turns each register-bus request into one APB SETUP/ACCESS transfer and returns the completion as a single-cycle register-bus response.
- Adds a region check and a pready timeout so a hung completer cannot stall the register demux.

Parameters:
- BaseAddr, chimera_pkg::ExtCfgRegsRegionStart (0x3000_2000): region base, subtracted from the request address.
- RegionSize, 0x3000: region size in bytes.
- AddrWidth, 32: register-bus and APB address width.
- DataWidth, 32: data width, equal to chimera_pkg::RegDataWidth.
- TimeoutCycles, 256: maximum ACCESS cycles waiting for pready; 0 disables the timeout.
- reg_req_t / reg_rsp_t, type: register-bus structs (valid, write, addr, wdata, wstrb / ready, rdata, error).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- reg_req_i  in  reg_req_t  register-bus request
- reg_rsp_o  out  reg_rsp_t  register-bus response
- apb_req_o  out  chimera_pkg::apb_req_t  APB request: psel, penable, pwrite, paddr, pwdata, pstrb, pprot
- apb_rsp_i  in  chimera_pkg::apb_resp_t  APB response: pready, prdata, pslverr
- busy_o  out  1  high whenever the state is not IDLE

Behaviour:
- One clock domain; reset is asynchronous and active-low. Reset forces state IDLE and clears every output and internal register: psel=0, penable=0, paddr=0, pwdata=0, pstrb=0, rsp.ready=0, rsp.rdata=0, rsp.error=0, timeout counter=0.
- Register-bus rules:
  - The requester holds valid and its fields stable until ready.
  - ready is high for exactly one cycle per request.
  - rdata and error are valid only while ready is high.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On reg_req.valid, latch write, addr, wdata and wstrb.
  - If BaseAddr <= addr < BaseAddr+RegionSize, go to SETUP.
  - Otherwise go to RESP with error=1 and rdata=0; no APB activity.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0, paddr = addr-BaseAddr (zero-extended to AddrWidth), pwrite = latched write.
  - pwdata = wdata on writes, 0 on reads.
  - pstrb = wstrb on writes, 0 on reads.
  - pprot = 3'b000.
  - Next state: ACCESS.
- ACCESS:
  - psel=1, penable=1; all other APB fields held stable.
  - On pready=1, capture prdata (reads only, else 0) and pslverr into the response registers, then go to RESP.
  - Each cycle with pready=0 increments the counter. When the counter reaches TimeoutCycles-1 with pready still 0, go to RESP with error=1 and rdata=0, and deassert psel in the next cycle.
  - pready=1 in the same cycle as the counter expiry counts as normal completion.
  - The counter clears on every entry to SETUP.
- RESP (1 cycle): rsp.ready=1 with the registered rdata and error; psel=0, penable=0. Next state: IDLE.
- Latency for an in-range request with zero-wait-state pready: valid seen at cycle 0, SETUP at 1, ACCESS at 2, ready at 3.
- A new request is not sampled in RESP. A valid held through RESP is ignored because it is the completed request; the next request is accepted in IDLE at the earliest one cycle after ready.
- Because valid is held until ready, the latched request is taken only in IDLE; a valid that changes mid-transfer is a protocol violation and is not checked.
- Reset asserted mid-transfer drops psel/penable immediately and returns to IDLE with no response issued.

Decomposition:
- chimera_pkg provides:
  - the apb_req_t / apb_resp_t typedefs, which already exist;
  - new constants ExtCfgRegsTimeoutCycles=256 and ExtCfgRegsRegionSize = ExtCfgRegsRegionEnd-ExtCfgRegsRegionStart.
- Sub-module: none. FSM, latch registers and counter live in one module of about 200 lines.

Test Plan:
- Write, addr=0x3000_2010, wdata=0xDEAD_BEEF, wstrb=0xF, pready tied 1 → SETUP at cycle 1 with paddr=0x010 and pstrb=0xF; penable at cycle 2; rsp.ready=1 and error=0 at cycle 3; exactly one APB transfer.
- Read, addr=0x3000_4FFC, completer inserts 3 wait states and returns prdata=0x1234_5678 → pwdata=0 and pstrb=0; ACCESS lasts 4 cycles; rsp.rdata=0x1234_5678 one cycle after pready.
- Read at 0x3000_5000 (first out-of-range address) → psel stays 0 throughout; rsp.ready=1 at cycle 1 with error=1 and rdata=0.
- Write with pready=1 and pslverr=1 → rsp.error=1; a following read to 0x3000_2000 completes normally with error=0.
- pready held 0 with TimeoutCycles=256 → after 256 ACCESS cycles rsp.ready=1 with error=1; psel=0 the next cycle; busy_o=0 afterwards.
- rst_ni asserted during ACCESS → psel, penable and busy_o go to 0 asynchronously; no rsp.ready pulse; after reset release a new write completes with standard 3-cycle latency.
